// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for a shared single-ported memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    // instruction fetch side
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_valid,
    output logic [DATA_W-1:0]   o_if_rdata,
    // load/store side
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_mask,
    output logic                o_d_gnt,
    output logic                o_d_valid,
    output logic [DATA_W-1:0]   o_d_rdata,
    // unified memory side
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_mask,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    // control
    input  logic                i_halt,
    output logic                o_halted
);

    localparam int         MASK_W     = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_WAIT = 2'd1,
        S_D_WAIT  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [3:0]          starve_q,    starve_d;
    logic                halt_q,      halt_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_mask_q,  mem_mask_d;
    logic                if_valid_q,  if_valid_d;
    logic                d_valid_q,   d_valid_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

    logic if_blocked;
    logic d_win;
    logic if_win;
    logic if_gnt;
    logic d_gnt;

    // Data wins unless fetch has lost STARVE_MAX times in a row; a blocked or
    // absent fetch never holds data off, so the count cannot deadlock data.
    assign if_blocked = halt_q;
    assign d_win      = i_d_req && ((starve_q < STARVE_MAX) || !i_if_req || if_blocked);
    assign if_win     = !d_win && i_if_req && !if_blocked;

    // Next-state, arbitration and command capture; grants only leave IDLE.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        halt_d      = halt_q | i_halt;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mask_d  = mem_mask_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_win) begin
                    d_gnt       = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = i_d_we;
                    mem_addr_d  = i_d_addr;
                    mem_wdata_d = i_d_wdata;
                    mem_mask_d  = i_d_mask;
                    state_d     = S_D_WAIT;
                    if (i_if_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_win) begin
                    if_gnt      = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_if_addr;
                    mem_wdata_d = '0;
                    mem_mask_d  = '0;
                    starve_d    = 4'd0;
                    state_d     = S_IF_WAIT;
                end
            end
            S_IF_WAIT: begin
                if (i_mem_ack) begin
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = i_mem_rdata;
                    state_d    = S_IDLE;
                end
            end
            S_D_WAIT: begin
                if (i_mem_ack) begin
                    mem_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = i_mem_rdata;
                    end
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command, response, starvation and halt registers; reset drops any
    // in-flight command at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            starve_q    <= 4'd0;
            halt_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mask_q  <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            starve_q    <= starve_d;
            halt_q      <= halt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mask_q  <= mem_mask_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_d_gnt     = d_gnt;
    assign o_if_valid  = if_valid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_valid   = d_valid_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_mask  = mem_mask_q;
    assign o_halted    = halt_q && (state_q == S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          len;
    } cmd_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        o_if_gnt, o_if_valid;
    logic [31:0] o_if_rdata;
    logic        i_d_req = 1'b0, i_d_we = 1'b0;
    logic [31:0] i_d_addr = '0, i_d_wdata = '0;
    logic [3:0]  i_d_mask = '0;
    logic        o_d_gnt, o_d_valid;
    logic [31:0] o_d_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        i_halt = 1'b0;
    logic        o_halted;

    int checks = 0;
    int errors = 0;

    int          gnt_q[$];
    cmd_t        cmd_q[$];
    logic [31:0] ifv_q[$];
    logic [31:0] dv_q[$];

    int          wait_n = 0;
    logic [31:0] rdata_val = '0;
    bit          force_ack = 1'b0;
    bit          halt_pulse = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(3)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata), .i_d_mask(i_d_mask),
        .o_d_gnt(o_d_gnt), .o_d_valid(o_d_valid), .o_d_rdata(o_d_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .i_halt(i_halt), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory model: acks after wait_n extra cycles of o_mem_req.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = 32'hFFFF_FFFF;
                wcnt        = 0;
            end else if (o_mem_req) begin
                if (wcnt >= wait_n) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = rdata_val;
                    wcnt        = 0;
                end else begin
                    i_mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                i_mem_ack = 1'b0;
                wcnt      = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a gnt, command or valid.
    initial begin
        int   cyc, gnt_cyc, lat_exp, run;
        bit   cmd_active;
        cmd_t cur;
        cyc = 0; gnt_cyc = 0; lat_exp = 0; run = 0; cmd_active = 1'b0;
        cur = '{we: 1'b0, addr: '0, wdata: '0, mask: '0, len: 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (!i_rst) begin
                cmd_active = 1'b0;
            end else begin
                if (o_if_valid) begin
                    if (ifv_q.size() == 0) fail("unexpected_if_valid");
                    else begin
                        chk("if_rdata", o_if_rdata, ifv_q.pop_front());
                        chk("if_latency", cyc - gnt_cyc, lat_exp);
                    end
                end
                if (o_d_valid) begin
                    if (dv_q.size() == 0) fail("unexpected_d_valid");
                    else begin
                        chk("d_rdata", o_d_rdata, dv_q.pop_front());
                        chk("d_latency", cyc - gnt_cyc, lat_exp);
                    end
                end
                if (o_if_gnt && o_d_gnt) fail("double_gnt");
                else if (o_if_gnt || o_d_gnt) begin
                    if (cmd_active || o_mem_req) fail("gnt_while_busy");
                    if (gnt_q.size() == 0) fail("unexpected_gnt");
                    else chk("gnt_kind_d", o_d_gnt, gnt_q.pop_front());
                    gnt_cyc = cyc;
                end
                if (o_mem_req) begin
                    if (!cmd_active) begin
                        if (cmd_q.size() == 0) fail("unexpected_mem_req");
                        else begin
                            cur        = cmd_q.pop_front();
                            cmd_active = 1'b1;
                            run        = 0;
                        end
                    end
                    if (cmd_active) begin
                        chk("mem_we", o_mem_we, cur.we);
                        chk("mem_addr", o_mem_addr, cur.addr);
                        if (cur.we) begin
                            chk("mem_wdata", o_mem_wdata, cur.wdata);
                            chk("mem_mask", o_mem_mask, cur.mask);
                        end
                        run++;
                        if (i_mem_ack) begin
                            if (cur.len != 0) chk("mem_req_len", run, cur.len);
                            lat_exp    = cur.len + 1;
                            cmd_active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // One request: push expectations, hold until granted, scramble inputs, wait for valid.
    task automatic issue(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input int nwait,
                         input logic [31:0] rdata, input logic [31:0] dexp, output int waited);
        cmd_t c;
        int   k;
        c = '{we: we, addr: addr, wdata: wdata, mask: mask, len: nwait + 1};
        gnt_q.push_back(is_d ? 1 : 0);
        cmd_q.push_back(c);
        if (is_d) dv_q.push_back(we ? dexp : rdata);
        else      ifv_q.push_back(rdata);
        wait_n    = nwait;
        rdata_val = rdata;
        if (is_d) begin
            i_d_req = 1'b1; i_d_we = we; i_d_addr = addr; i_d_wdata = wdata; i_d_mask = mask;
        end else begin
            i_if_req = 1'b1; i_if_addr = addr;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            if (is_d ? o_d_gnt : o_if_gnt) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) fail("gnt_timeout");
        @(posedge clk);
        #1;
        if (is_d) begin
            i_d_req = 1'b0; i_d_we = ~we; i_d_addr = 32'hBAD0_BAD0;
            i_d_wdata = 32'h0BAD_0BAD; i_d_mask = ~mask;
        end else begin
            i_if_req = 1'b0; i_if_addr = 32'hBAD1_BAD1;
        end
        if (halt_pulse) begin
            i_halt = 1'b1;
            @(posedge clk);
            #1;
            i_halt = 1'b0;
        end
        for (k = 0; k < 60; k++) begin
            @(posedge clk);
            if ((is_d ? dv_q.size() : ifv_q.size()) == 0) break;
        end
        if (k == 60) fail("valid_timeout");
        #1;
    endtask

    initial begin
        int w;
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", o_if_gnt, 0);
        chk("rst_d_gnt", o_d_gnt, 0);
        chk("rst_valids", {o_if_valid, o_d_valid}, 0);
        chk("rst_rdata", {o_if_rdata, o_d_rdata}, 0);
        chk("rst_mem_req", o_mem_req, 0);
        chk("rst_mem_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask}, 0);
        chk("rst_halted", o_halted, 0);
        @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk);
        #1;

        // Single zero-wait fetch
        issue(1'b0, 1'b0, 32'h100, '0, '0, 0, 32'h0000_0013, '0, w);
        chk("fetch_gnt_cycle0", w, 0);

        // Load with 3 wait states
        issue(1'b1, 1'b0, 32'h2000, '0, 4'hF, 3, 32'hCAFE_F00D, '0, w);

        // Both held: D,D,D,IF,D,D,D,IF
        wait_n = 0;
        rdata_val = 32'h55;
        for (int i = 0; i < 8; i++) begin
            bit is_if;
            is_if = (i == 3) || (i == 7);
            gnt_q.push_back(is_if ? 0 : 1);
            cmd_q.push_back('{we: 1'b0, addr: is_if ? 32'h300 : 32'h400, wdata: '0, mask: '0, len: 1});
            if (is_if) ifv_q.push_back(32'h55);
            else       dv_q.push_back(32'h55);
        end
        i_if_req = 1'b1; i_if_addr = 32'h300;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h400; i_d_mask = 4'hF;
        n = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            @(negedge clk);
            if (o_if_gnt || o_d_gnt) n++;
        end
        chk("prio_gnt_count", n, 8);
        @(posedge clk);
        #1;
        i_if_req = 1'b0; i_d_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Store: o_d_rdata keeps the last load value
        issue(1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'hF, 1, 32'h1234_5678, 32'h55, w);

        // Stray acks while idle are ignored
        @(negedge clk);
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Halt raised during IF_WAIT
        @(negedge clk);
        chk("halted_before", o_halted, 0);
        @(posedge clk);
        #1;
        halt_pulse = 1'b1;
        issue(1'b0, 1'b0, 32'h500, '0, '0, 2, 32'h77, '0, w);
        halt_pulse = 1'b0;
        i_if_req = 1'b1; i_if_addr = 32'h600;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("halted_idle", o_halted, 1);
        end
        @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 32'h700, '0, 4'hF, 0, 32'h99, '0, w);
        chk("halt_d_gnt_cycle0", w, 0);
        i_if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during D_WAIT
        gnt_q.push_back(1);
        cmd_q.push_back('{we: 1'b0, addr: 32'h900, wdata: '0, mask: '0, len: 0});
        wait_n = 10;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h900;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_d_gnt) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) fail("rst_test_gnt_timeout");
        @(posedge clk);
        #1;
        i_d_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        i_rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", o_mem_req, 0);
        chk("rst_mid_d_valid", o_d_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("post_rst_halted", o_halted, 0);
        chk("post_rst_d_rdata", o_d_rdata, 0);
        @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 32'h800, '0, '0, 0, 32'h1, '0, w);
        chk("post_rst_idle_gnt", w, 0);

        repeat (4) @(posedge clk);
        chk("queues_empty", gnt_q.size() + cmd_q.size() + ifv_q.size() + dv_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
